seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//   Time-multiplexed refresh controller for the 4-digit seven-segment display.
//   Generates the active-low anode scan for the downstream decoder.
//   Holds a frame-stable copy of the four 4-bit display values (A, B, A+B, A-B).
//   Inserts blanking dead-time between digits to suppress ghosting.
// PARAMETERS
//   TICK_DIV      100000  clk cycles per digit slot (blank + drive); must be > BLANK_CYCLES
//   BLANK_CYCLES  8       cycles per slot with all anodes off, at slot start; 0 = no blanking
// PORTS
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   enable     in   1  scan enable; 0 forces display dark
//   dig_en     in   4  per-digit enable mask, bit i = digit i; 0 keeps that anode off
//   din_a      in   4  value for digit 0 (anode 4'b1110)
//   din_b      in   4  value for digit 1 (anode 4'b1101)
//   din_sum    in   4  value for digit 2 (anode 4'b1011)
//   din_diff   in   4  value for digit 3 (anode 4'b0111)
//   load       in   1  update request (level), held until load_ack
//   load_ack   out  1  1-cycle pulse: din_* captured this cycle
//   a_q        out  4  latched digit-0 value to decoder
//   b_q        out  4  latched digit-1 value to decoder
//   sum_q      out  4  latched digit-2 value to decoder
//   diff_q     out  4  latched digit-3 value to decoder
//   anode      out  4  active-low anode drive, at most one bit low
//   frame_done out  1  1-cycle pulse at end of digit-3 slot
// BEHAVIOUR
//   Reset (async assert, sync release):
//     anode=4'b1111; a_q/b_q/sum_q/diff_q=0; load_ack=0; frame_done=0;
//     idx=0; cnt=0; state=IDLE.
//   All outputs are registered.
//   FSM states: IDLE, BLANK, DRIVE.
//     IDLE: anode=1111, cnt=0, idx=0.
//       enable=1 -> BLANK, or -> DRIVE if BLANK_CYCLES=0.
//     BLANK: anode=1111; cnt counts 0..BLANK_CYCLES-1, then -> DRIVE.
//     DRIVE: anode = ~(4'b0001<<idx) if dig_en[idx], else 1111.
//       cnt continues to TICK_DIV-1, then cnt=0 and idx=idx+1 (mod 4).
//       Next state is BLANK, or DRIVE if BLANK_CYCLES=0.
//   Timing: each slot is exactly TICK_DIV cycles; one frame = 4*TICK_DIV cycles.
//     The slot length is the same whether or not the digit is masked.
//   frame_done: pulses on the last DRIVE cycle of idx=3 (cnt=TICK_DIV-1).
//   Load handshake:
//     Capture din_* into *_q and pulse load_ack in the same cycle when load=1 and either:
//       (a) the frame_done cycle, or
//       (b) state=IDLE.
//     Values are therefore never torn mid-frame.
//     load=0 on a boundary: no capture, *_q hold.
//     After ack, a load still high is a new request. Capture repeats at the next boundary.
//   enable falls mid-slot: the next cycle goes to IDLE (anode=1111, idx=0, cnt=0).
//     No frame_done is issued for the aborted frame.
//   enable rises: the scan restarts at digit 0, cnt=0.
//   Reset mid-frame: immediate return to reset values. Any pending load is dropped,
//     so the requester must re-present it.
//   dig_en is sampled every cycle. A change takes effect on the next anode update.
// TESTING (TICK_DIV=10, BLANK_CYCLES=2 unless noted)
//   1. Reset release, enable=1, dig_en=F -> anode pattern 1111x2, then 1110x8,
//      1111x2, 1101x8, ... 0111x8; frame_done pulses at cycle 39; pattern repeats.
//   2. load=1, din_a=3, din_b=5, din_sum=8, din_diff=E, mid-frame -> *_q unchanged
//      until the frame_done cycle; load_ack pulses in that cycle; a_q=3, sum_q=8.
//   3. enable=0, load=1, din_a=9 -> load_ack on the next cycle, a_q=9, anode=1111.
//   4. dig_en=4'b1010 -> anode never 1110 or 1011; those slots are all 1111;
//      frame period stays 40 cycles.
//   5. enable dropped at cycle 15 (digit-1 drive) -> anode=1111 from cycle 16, no
//      frame_done; enable re-raised -> first drive is 1110 after 2 blank cycles.
//   6. rst_n pulsed low mid-slot with load pending -> all outputs reset
//      asynchronously, no load_ack; BLANK_CYCLES=0 rerun: no 1111 gaps between digits.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed refresh controller for a 4-digit seven-segment display.
// Drives an active-low anode scan with blanking dead-time and frame-stable digit values.
module seven_seg_scan_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] dig_en,
  input  logic [3:0] din_a,
  input  logic [3:0] din_b,
  input  logic [3:0] din_sum,
  input  logic [3:0] din_diff,
  input  logic       load,
  output logic       load_ack,
  output logic [3:0] a_q,
  output logic [3:0] b_q,
  output logic [3:0] sum_q,
  output logic [3:0] diff_q,
  output logic [3:0] anode,
  output logic       frame_done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Where a slot starts after IDLE or after a completed slot.
  localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_anode;
  logic             r_frame_done;
  logic             r_load_ack;
  logic [3:0]       r_a_q;
  logic [3:0]       r_b_q;
  logic [3:0]       r_sum_q;
  logic [3:0]       r_diff_q;

  state_t           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [1:0]       w_nxt_idx;
  logic             w_frame_end;
  logic             w_capture;
  logic [3:0]       w_anode_nxt;

  // Outputs are registered from next-state values so they line up with the
  // state they describe rather than lagging it by a cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_idx   = r_idx;
    if (!enable) begin
      w_nxt_state = IDLE;
      w_nxt_cnt   = '0;
      w_nxt_idx   = 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt_state = SLOT_START;
          w_nxt_cnt   = '0;
          w_nxt_idx   = 2'd0;
        end
        BLANK: begin
          w_nxt_cnt = r_cnt + CNT_ONE;
          if (r_cnt == BLANK_LAST) w_nxt_state = DRIVE;
        end
        DRIVE: begin
          if (r_cnt == TICK_LAST) begin
            w_nxt_cnt   = '0;
            w_nxt_idx   = r_idx + 2'd1;
            w_nxt_state = SLOT_START;
          end else begin
            w_nxt_cnt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = '0;
          w_nxt_idx   = 2'd0;
        end
      endcase
    end
  end

  assign w_frame_end = (w_nxt_state == DRIVE) && (w_nxt_idx == 2'd3) && (w_nxt_cnt == TICK_LAST);
  assign w_capture   = load && (w_frame_end || (w_nxt_state == IDLE));
  assign w_anode_nxt = ((w_nxt_state == DRIVE) && dig_en[w_nxt_idx]) ? ~(4'b0001 << w_nxt_idx)
                                                                     : 4'b1111;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_anode      <= 4'b1111;
      r_frame_done <= 1'b0;
      r_load_ack   <= 1'b0;
      r_a_q        <= 4'd0;
      r_b_q        <= 4'd0;
      r_sum_q      <= 4'd0;
      r_diff_q     <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the pre-edge value of every other register.
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_idx        <= w_nxt_idx;
      r_anode      <= w_anode_nxt;
      r_frame_done <= w_frame_end;
      r_load_ack   <= w_capture;
      if (w_capture) begin
        r_a_q    <= din_a;
        r_b_q    <= din_b;
        r_sum_q  <= din_sum;
        r_diff_q <= din_diff;
      end
    end
  end

  assign anode      = r_anode;
  assign frame_done = r_frame_done;
  assign load_ack   = r_load_ack;
  assign a_q        = r_a_q;
  assign b_q        = r_b_q;
  assign sum_q      = r_sum_q;
  assign diff_q     = r_diff_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl (TICK_DIV=10).
// u_dut uses BLANK_CYCLES=2; u_dut_nb uses BLANK_CYCLES=0 and shares all inputs.
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] dig_en;
  logic [3:0] din_a, din_b, din_sum, din_diff;
  logic       load;

  logic       load_ack, frame_done;
  logic [3:0] a_q, b_q, sum_q, diff_q, anode;
  logic       nb_load_ack, nb_frame_done;
  logic [3:0] nb_a_q, nb_b_q, nb_sum_q, nb_diff_q, nb_anode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.TICK_DIV(10), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dig_en(dig_en),
    .din_a(din_a), .din_b(din_b), .din_sum(din_sum), .din_diff(din_diff),
    .load(load), .load_ack(load_ack), .a_q(a_q), .b_q(b_q), .sum_q(sum_q),
    .diff_q(diff_q), .anode(anode), .frame_done(frame_done)
  );

  seven_seg_scan_ctrl #(.TICK_DIV(10), .BLANK_CYCLES(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dig_en(dig_en),
    .din_a(din_a), .din_b(din_b), .din_sum(din_sum), .din_diff(din_diff),
    .load(load), .load_ack(nb_load_ack), .a_q(nb_a_q), .b_q(nb_b_q), .sum_q(nb_sum_q),
    .diff_q(nb_diff_q), .anode(nb_anode), .frame_done(nb_frame_done)
  );

  // Expected anode for cycle c of a scan that started from IDLE at cycle 0.
  function automatic logic [3:0] exp_anode(input int c, input logic [3:0] en, input int blank);
    int slot;
    int pos;
    slot = (c / 10) % 4;
    pos  = c % 10;
    if (pos < blank || !en[slot]) return 4'b1111;
    return ~(4'b0001 << slot);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; dig_en = 4'hF; load = 1'b0;
    din_a = 4'h0; din_b = 4'h0; din_sum = 4'h0; din_diff = 4'h0;
    tick(); tick();
    n_tests++;
    if (anode !== 4'b1111) begin n_fail++; $display("FAIL reset_anode got=%b exp=1111", anode); end
    n_tests++;
    if ({a_q, b_q, sum_q, diff_q} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_q got=%h exp=0000", {a_q, b_q, sum_q, diff_q});
    end
    n_tests++;
    if ({load_ack, frame_done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_pulses got=%b exp=00", {load_ack, frame_done});
    end
  endtask

  task automatic test_scan();
    enable = 1'b1; dig_en = 4'hF;
    rst_n  = 1'b1;
    for (int c = 0; c < 80; c++) begin
      tick();
      n_tests++;
      if (anode !== exp_anode(c, 4'hF, 2) || frame_done !== (c % 40 == 39)) begin
        n_fail++;
        $display("FAIL scan c=%0d anode=%b exp=%b fd=%b exp=%b", c, anode,
                 exp_anode(c, 4'hF, 2), frame_done, (c % 40 == 39));
      end
    end
  endtask

  task automatic test_load_frame();
    int waited;
    int period;
    din_a = 4'h3; din_b = 4'h5; din_sum = 4'h8; din_diff = 4'hE;
    load  = 1'b1;
    waited = 0;
    do begin
      tick(); waited++;
      if (!frame_done) begin
        n_tests++;
        if (load_ack !== 1'b0 || a_q !== 4'h0) begin
          n_fail++; $display("FAIL load_torn cyc=%0d ack=%b a_q=%h exp ack=0 a_q=0", waited, load_ack, a_q);
        end
      end
    end while (!frame_done && waited < 50);
    n_tests++;
    if (!frame_done) begin n_fail++; $display("FAIL load_wait no frame_done in 50 cycles"); end
    n_tests++;
    if (load_ack !== 1'b1 || {a_q, b_q, sum_q, diff_q} !== 16'h358E) begin
      n_fail++; $display("FAIL load_capture ack=%b q=%h exp ack=1 q=358e", load_ack, {a_q, b_q, sum_q, diff_q});
    end
    load = 1'b0;
    din_a = 4'h1; din_b = 4'h2; din_sum = 4'h3; din_diff = 4'h4;
    tick();
    n_tests++;
    if (load_ack !== 1'b0) begin n_fail++; $display("FAIL load_ack_pulse got=%b exp=0", load_ack); end
    period = 1;
    while (!frame_done && period < 50) begin tick(); period++; end
    n_tests++;
    if (period !== 40) begin n_fail++; $display("FAIL frame_period got=%0d exp=40", period); end
    n_tests++;
    if (load_ack !== 1'b0 || {a_q, b_q, sum_q, diff_q} !== 16'h358E) begin
      n_fail++; $display("FAIL load_hold ack=%b q=%h exp ack=0 q=358e", load_ack, {a_q, b_q, sum_q, diff_q});
    end
  endtask

  task automatic test_load_idle();
    enable = 1'b0; load = 1'b1;
    din_a = 4'h9; din_b = 4'h6; din_sum = 4'h7; din_diff = 4'hC;
    tick();
    n_tests++;
    if (load_ack !== 1'b1 || {a_q, b_q, sum_q, diff_q} !== 16'h967C || anode !== 4'b1111) begin
      n_fail++; $display("FAIL load_idle ack=%b q=%h anode=%b exp ack=1 q=967c anode=1111",
                         load_ack, {a_q, b_q, sum_q, diff_q}, anode);
    end
    load = 1'b0; din_a = 4'hF;
    tick();
    n_tests++;
    if (load_ack !== 1'b0 || a_q !== 4'h9) begin
      n_fail++; $display("FAIL load_idle_hold ack=%b a_q=%h exp ack=0 a_q=9", load_ack, a_q);
    end
  endtask

  task automatic test_mask();
    dig_en = 4'b1010; enable = 1'b1;
    for (int c = 0; c < 80; c++) begin
      tick();
      n_tests++;
      if (anode !== exp_anode(c, 4'b1010, 2) || frame_done !== (c % 40 == 39)) begin
        n_fail++;
        $display("FAIL mask c=%0d anode=%b exp=%b fd=%b exp=%b", c, anode,
                 exp_anode(c, 4'b1010, 2), frame_done, (c % 40 == 39));
      end
    end
    enable = 1'b0; dig_en = 4'hF;
    tick();
  endtask

  task automatic test_enable_drop();
    logic [3:0] exp_rise [3];
    exp_rise[0] = 4'b1111; exp_rise[1] = 4'b1111; exp_rise[2] = 4'b1110;
    enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      n_tests++;
      if (anode !== exp_anode(c, 4'hF, 2)) begin
        n_fail++; $display("FAIL drop_pre c=%0d anode=%b exp=%b", c, anode, exp_anode(c, 4'hF, 2));
      end
    end
    enable = 1'b0;
    for (int c = 16; c < 56; c++) begin
      tick();
      n_tests++;
      if (anode !== 4'b1111 || frame_done !== 1'b0) begin
        n_fail++; $display("FAIL drop_dark c=%0d anode=%b fd=%b exp anode=1111 fd=0", c, anode, frame_done);
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (anode !== exp_rise[c]) begin
        n_fail++; $display("FAIL drop_restart c=%0d anode=%b exp=%b", c, anode, exp_rise[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(); tick(); tick();
    load = 1'b1;
    din_a = 4'h1; din_b = 4'h2; din_sum = 4'h3; din_diff = 4'h4;
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (anode !== 4'b1111 || {a_q, b_q, sum_q, diff_q} !== 16'h0000 ||
        load_ack !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_async anode=%b q=%h ack=%b fd=%b exp 1111/0000/0/0",
                         anode, {a_q, b_q, sum_q, diff_q}, load_ack, frame_done);
    end
    load = 1'b0;
    tick(); tick();
    n_tests++;
    if (anode !== 4'b1111 || load_ack !== 1'b0 || a_q !== 4'h0) begin
      n_fail++; $display("FAIL reset_hold anode=%b ack=%b a_q=%h exp 1111/0/0", anode, load_ack, a_q);
    end
  endtask

  task automatic test_no_blank();
    enable = 1'b1; dig_en = 4'hF;
    rst_n  = 1'b1;
    for (int c = 0; c < 80; c++) begin
      tick();
      n_tests++;
      if (nb_anode !== exp_anode(c, 4'hF, 0) || nb_frame_done !== (c % 40 == 39) || nb_load_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL no_blank c=%0d anode=%b exp=%b fd=%b exp=%b ack=%b exp=0", c, nb_anode,
                 exp_anode(c, 4'hF, 0), nb_frame_done, (c % 40 == 39), nb_load_ack);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_load_frame();
    test_load_idle();
    test_mask();
    test_enable_drop();
    test_reset_mid();
    test_no_blank();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
